// File: rtl/gray_window_buffer.sv
// 3x3 sliding-window generator over a raster grayscale stream, backed by two
// line buffers; flags in-frame windows and the end of each frame.
module gray_window_buffer #(
  parameter int P_PIXEL_DEPTH  = 24,
  parameter int P_GRAY_DEPTH   = 8,
  parameter int P_IMAGE_WIDTH  = 640,
  parameter int P_IMAGE_HEIGHT = 480
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic                        I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]    I_PIXEL,
  output logic [9*P_GRAY_DEPTH-1:0]   O_WINDOW,
  output logic                        O_VALID,
  output logic                        O_FRAME_DONE
);

  localparam int CW = (P_IMAGE_WIDTH  > 1) ? $clog2(P_IMAGE_WIDTH)  : 1;
  localparam int RW = (P_IMAGE_HEIGHT > 1) ? $clog2(P_IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(P_IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(P_IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef logic [P_GRAY_DEPTH-1:0] gray_t;

  gray_t lb0_q [P_IMAGE_WIDTH];
  gray_t lb1_q [P_IMAGE_WIDTH];

  // [row][col], so element [0][0] (top-left) lands in the MSBs when flattened
  logic [0:2][0:2][P_GRAY_DEPTH-1:0] win_q, win_d;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;

  gray_t pix;
  logic  unused_pix_hi;

  assign pix           = I_PIXEL[P_GRAY_DEPTH-1:0];
  assign unused_pix_hi = ^I_PIXEL[P_PIXEL_DEPTH-1:P_GRAY_DEPTH];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    vld_d  = 1'b0;
    done_d = 1'b0;
    if (I_ENABLE) begin
      for (int k = 0; k < 3; k++) begin
        win_d[k][0] = win_q[k][1];
        win_d[k][1] = win_q[k][2];
      end
      win_d[0][2] = lb0_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = pix;
      // columns 0/1 straddle a line wrap, rows 0/1 lack two lines above
      vld_d  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
      done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      col_q  <= '0;
      row_q  <= '0;
      win_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      win_q  <= win_d;
      vld_q  <= vld_d;
      done_q <= done_d;
    end
  end

  // Line buffers carry no reset; stale contents are masked by the valid gating.
  always_ff @(posedge I_CLK) begin
    if (I_ENABLE && !I_RESET) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix;
    end
  end

  assign O_WINDOW     = win_q;
  assign O_VALID      = vld_q;
  assign O_FRAME_DONE = done_q;

endmodule

// File: tb/tb_gray_window_buffer.sv
// Directed plus randomized bench for gray_window_buffer on a 4x4 frame, checked
// against a pixel-history reference model.
module tb_gray_window_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PD = 24;
  localparam int GD = 8;

  logic          clk;
  logic          I_RESET;
  logic          I_ENABLE;
  logic [PD-1:0] I_PIXEL;
  logic [9*GD-1:0] O_WINDOW;
  logic          O_VALID;
  logic          O_FRAME_DONE;

  gray_window_buffer #(
    .P_PIXEL_DEPTH (PD),
    .P_GRAY_DEPTH  (GD),
    .P_IMAGE_WIDTH (W),
    .P_IMAGE_HEIGHT(H)
  ) dut (
    .I_CLK       (clk),
    .I_RESET     (I_RESET),
    .I_ENABLE    (I_ENABLE),
    .I_PIXEL     (I_PIXEL),
    .O_WINDOW    (O_WINDOW),
    .O_VALID     (O_VALID),
    .O_FRAME_DONE(O_FRAME_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int nvld       = 0;
  int ndone      = 0;

  // every pixel accepted since the last reset, in acceptance order
  logic [7:0] hist[$];
  logic       ev, ed;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window column j comes from the accept (2-j) steps back; its row k comes
  // from (2-k) lines earlier in the stream. Before any accept the window holds
  // its reset zeros; data older than the last reset is unknown and masked.
  function automatic void model_win(output logic [71:0] w, output logic [71:0] m);
    int n = hist.size();
    w = '0;
    m = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        int a   = n - 1 - (2 - j);
        int e   = a - (2 - k) * W;
        int off = (8 - (k * 3 + j)) * 8;
        if (a < 0) begin
          m[off +: 8] = 8'hFF;
        end else if (e >= 0) begin
          w[off +: 8] = hist[e];
          m[off +: 8] = 8'hFF;
        end
      end
    end
  endfunction

  task automatic step(input logic rst, input logic en, input logic [7:0] p);
    logic [71:0] w, m;
    int i, r, c;
    I_RESET  = rst;
    I_ENABLE = en;
    I_PIXEL  = {3{p}};
    @(posedge clk);
    if (rst) begin
      hist.delete();
      ev = 1'b0;
      ed = 1'b0;
    end else if (en) begin
      hist.push_back(p);
      i  = hist.size() - 1;
      r  = (i / W) % H;
      c  = i % W;
      ev = (r >= 2) && (c >= 2);
      ed = (r == H - 1) && (c == W - 1);
    end else begin
      ev = 1'b0;
      ed = 1'b0;
    end
    #1;
    model_win(w, m);
    check("valid", 72'(O_VALID), 72'(ev));
    check("frame_done", 72'(O_FRAME_DONE), 72'(ed));
    check("window", O_WINDOW & m, w & m);
    if (O_VALID) nvld++;
    if (O_FRAME_DONE) ndone++;
  endtask

  function automatic logic [7:0] px(input logic [7:0] base, input int r, input int c);
    return base + 8'(16 * r + c);
  endfunction

  // Full frame; optional 3-cycle stall after pixel index stall_at; literal
  // checks on the first and last in-frame windows and on the strobe counts.
  task automatic frame(input logic [7:0] base, input int stall_at,
                       input logic [71:0] first_w, input logic [71:0] last_w);
    int v0 = nvld;
    int d0 = ndone;
    for (int i = 0; i < W * H; i++) begin
      step(1'b0, 1'b1, px(base, i / W, i % W));
      if (i == 2 * W + 2) check("first_window", O_WINDOW, first_w);
      if (i == W * H - 1) begin
        check("last_window", O_WINDOW, last_w);
        check("last_done", 72'(O_FRAME_DONE), 72'(1));
      end
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) step(1'b0, 1'b0, 8'hEE);
      end
    end
    check("strobe_count", 72'(nvld - v0), 72'((H - 2) * (W - 2)));
    check("done_count", 72'(ndone - d0), 72'(1));
  endtask

  localparam logic [71:0] WIN_FIRST  = 72'h000102101112202122;
  localparam logic [71:0] WIN_LAST   = 72'h111213212223313233;
  localparam logic [71:0] WIN2_FIRST = 72'h808182909192A0A1A2;
  localparam logic [71:0] WIN2_LAST  = 72'h919293A1A2A3B1B2B3;

  initial begin
    I_RESET  = 1'b1;
    I_ENABLE = 1'b0;
    I_PIXEL  = '0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("reset_window", O_WINDOW, 72'h0);

    // continuous frame, then a frame with a stall after (2,1)
    frame(8'h00, -1, WIN_FIRST, WIN_LAST);
    frame(8'h00, 2 * W + 1, WIN_FIRST, WIN_LAST);

    // back-to-back frames with distinct content
    frame(8'h00, -1, WIN_FIRST, WIN_LAST);
    frame(8'h80, -1, WIN2_FIRST, WIN2_LAST);

    // abort after (3,1), then a fresh frame
    for (int i = 0; i <= 3 * W + 1; i++) step(1'b0, 1'b1, px(8'h00, i / W, i % W));
    step(1'b1, 1'b0, 8'h00);
    check("abort_window", O_WINDOW, 72'h0);
    check("abort_valid", 72'(O_VALID), 72'(0));
    check("abort_done", 72'(O_FRAME_DONE), 72'(0));
    frame(8'h00, -1, WIN_FIRST, WIN_LAST);

    // reset together with enable drops the pixel
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, px(8'h40, i / W, i % W));
    step(1'b1, 1'b1, 8'h77);
    check("rst_en_window", O_WINDOW, 72'h0);
    frame(8'h00, -1, WIN_FIRST, WIN_LAST);

    // randomized stream with random stalls and occasional resets
    for (int n = 0; n < 400; n++) begin
      logic rr, ee;
      rr = ($urandom_range(0, 99) < 2);
      ee = ($urandom_range(0, 99) < 75);
      step(rr, ee, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
